sp_ram_fifo: RTL and testbench

Synchronous FIFO controller built around one instance of the team's single-port `ram` block (1-cycle registered read, no simultaneous read and write).
- Accepts a valid/ready write stream and arbitrates the single RAM port between pushes and prefetch reads.
- Hides read latency with a 2-entry output buffer (OB), so the consumer sees a standard valid/ready stream at up to 1 word/cycle.
- Sits directly upstream of the RAM and owns all of its control pins.

---
 rtl/sp_ram_fifo_pkg.sv | 8 +
 rtl/ram.sv | 21 ++
 rtl/sp_fifo_obuf.sv | 33 +++
 rtl/sp_ram_fifo.sv | 69 ++++++
 tb/tb_sp_ram_fifo.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/sp_ram_fifo_pkg.sv
// sp_ram_fifo_pkg: shared constants, port-operation type and pointer helper for the RAM-backed FIFO
package sp_ram_fifo_pkg;
  localparam int OB_DEPTH = 2;
  typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD} op_e;
  function automatic int ptr_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/ram.sv
// ram: single-port memory with registered read, one access per cycle
module ram #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE = 1024,
  localparam int ADDR_WIDTH = (MEM_SIZE == 1) ? 1 : $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  enable_write,
  input  logic                  enable_read,
  input  logic                  ctrl_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_write,
  output logic [DATA_WIDTH-1:0] data_read
);
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  // write when commanded, otherwise a read registers the addressed word
  always_ff @(posedge clk) begin
    if (enable_write && ctrl_write) mem[addr] <= data_write;
    if (enable_read && !ctrl_write) data_read <= mem[addr];
  end
endmodule

// File: rtl/sp_fifo_obuf.sv
// sp_fifo_obuf: two-entry output buffer that absorbs RAM read latency
module sp_fifo_obuf import sp_ram_fifo_pkg::*; #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  append,
  input  logic [DATA_WIDTH-1:0] append_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            ob_cnt
);
  logic [DATA_WIDTH-1:0] mem [OB_DEPTH];
  logic head;
  logic slot;
  assign slot = head ^ ob_cnt[0];
  assign out_valid = ob_cnt != 2'd0;
  assign out_data = mem[head];
  // append lands behind the head; when full with a pop it reuses the slot being freed
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= 1'b0;
      ob_cnt <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (append) mem[slot] <= append_data;
      if (pop) head <= ~head;
      ob_cnt <= ob_cnt + 2'(append) - 2'(pop);
    end
  end
endmodule

// File: rtl/sp_ram_fifo.sv
// sp_ram_fifo: FIFO over a single-port RAM with bypass and a 2-entry prefetch buffer
module sp_ram_fifo import sp_ram_fifo_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int ADDR_WIDTH = (DEPTH == 1) ? 1 : $clog2(DEPTH),
  localparam int CNT_WIDTH = $clog2(DEPTH + 3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  count
);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] ram_cnt;
  logic rd_pending, push, pop, bypass, ram_we, ram_re;
  logic [1:0] ob_cnt;
  logic [DATA_WIDTH-1:0] ram_q;
  op_e op;
  assign in_ready = ram_cnt != CNT_WIDTH'(DEPTH);
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign count = ram_cnt + CNT_WIDTH'(rd_pending) + CNT_WIDTH'(ob_cnt);
  // arbitrate the RAM port: pushes that cannot bypass win over prefetch reads
  always_comb begin
    bypass = push && ram_cnt == '0 && !rd_pending && (ob_cnt < 2'd2 || pop);
    op = (push && !bypass) ? OP_WR :
         (ram_cnt != '0 && (3'(ob_cnt) + 3'(rd_pending)) < (3'd2 + 3'(pop))) ? OP_RD : OP_IDLE;
    ram_we = op == OP_WR;
    ram_re = op == OP_RD;
  end
  // pointers, RAM occupancy and the one-deep read pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_cnt <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (ram_we) wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr), DEPTH));
      if (ram_re) rd_ptr <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr), DEPTH));
      ram_cnt <= ram_cnt + CNT_WIDTH'(ram_we) - CNT_WIDTH'(ram_re);
      rd_pending <= ram_re;
    end
  end
  ram #(.DATA_WIDTH(DATA_WIDTH), .MEM_SIZE(DEPTH)) u_ram (
    .clk(clk),
    .enable_write(ram_we),
    .enable_read(ram_re),
    .ctrl_write(ram_we),
    .addr(ram_we ? wr_ptr : rd_ptr),
    .data_write(in_data),
    .data_read(ram_q)
  );
  sp_fifo_obuf #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
    .clk(clk),
    .rst(rst),
    .append(bypass | rd_pending),
    .append_data(rd_pending ? ram_q : in_data),
    .pop(pop),
    .out_valid(out_valid),
    .out_data(out_data),
    .ob_cnt(ob_cnt)
  );
endmodule

// File: tb/tb_sp_ram_fifo.sv
// tb_sp_ram_fifo: queue-model and directed checks of the RAM-backed FIFO
module tb_sp_ram_fifo;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 3);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  int checks = 0;
  int failures = 0;
  int q[$];
  int got[$];
  int sent[$];
  int pushed = 0;
  sp_ram_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask
  // reference FIFO: contents follow accepted handshakes only
  always @(posedge clk) begin
    if (rst) q.delete();
    else begin
      if (in_valid && in_ready) begin
        q.push_back(int'(in_data));
        sent.push_back(int'(in_data));
        pushed++;
      end
      if (out_valid && out_ready) begin
        got.push_back(int'(out_data));
        if (q.size() > 0) q.pop_front();
      end
    end
  end
  // per-cycle comparison against the reference FIFO
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", int'(count), q.size());
      if (out_valid) chk("head_data", int'(out_data), q.size() > 0 ? q[0] : -1);
      if (q.size() == 0) chk("empty_valid", int'(out_valid), 0);
      chk("port_excl", int'(dut.ram_we & dut.ram_re), 0);
      if (q.size() < DEPTH) chk("ready_room", int'(in_ready), 1);
      if (q.size() == DEPTH + 2) chk("ready_full", int'(in_ready), 0);
    end
  end
  initial begin
    int base, bad;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_out_data", int'(out_data), 0);
    in_valid = 1'b1; in_data = 16'h0001; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 1);
    chk("t1_count", int'(count), 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_count_after", int'(count), 0);
    chk("t1_valid_after", int'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h10 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t2_count", int'(count), 6);
    chk("t2_ready", int'(in_ready), 0);
    in_valid = 1'b1; in_data = 16'h16;
    repeat (3) @(negedge clk);
    chk("t2_ready_hold", int'(in_ready), 0);
    chk("t2_count_hold", int'(count), 6);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t3_valid", int'(out_valid), 1);
      chk("t3_data", int'(out_data), 16'h10 + i);
      @(negedge clk);
    end
    chk("t3_count", int'(count), 0);
    chk("t3_ready", int'(in_ready), 1);
    chk("t3_valid_end", int'(out_valid), 0);
    got.delete();
    base = pushed;
    for (int c = 0; c < 600 && got.size() < 20; c++) begin
      in_valid = (pushed - base < 20) && 1'($urandom_range(0, 1));
      in_data = DW'(pushed - base);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t4_size", got.size(), 20);
    for (int i = 0; i < 20; i++) chk("t4_order", i < got.size() ? got[i] : -1, i);
    out_ready = 1'b0;
    sent.delete();
    got.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h100 + i);
      @(negedge clk);
    end
    chk("t5_count", int'(count), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h104 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 60 && got.size() < sent.size(); c++) @(negedge clk);
    chk("t5_size", got.size(), sent.size());
    bad = 0;
    for (int i = 0; i < sent.size(); i++) if (i >= got.size() || got[i] != sent[i]) bad++;
    chk("t5_order_errs", bad, 0);
    chk("t5_first", got.size() > 0 ? got[0] : -1, 16'h100);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h200 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t6_rd_pending", int'(dut.rd_pending), 1);
    chk("t6_count_pre", int'(count), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_count", int'(count), 0);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_stale", int'(out_valid), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
